// File: rtl/ones_pattern_gen_if.sv
// Handshake and result bundle for ones_pattern_gen.
// When ONES_PATTERN_GEN_SAT_ERR_EN is defined, the bundle also carries sat_err.
interface ones_pattern_gen_if #(
  parameter int data_width  = 4,
  parameter int count_width = 3
);
  logic                   start;
  logic [count_width-1:0] bit_count;
  logic [data_width-1:0]  data;
  logic                   busy;
  logic                   done;
`ifdef ONES_PATTERN_GEN_SAT_ERR_EN
  logic                   sat_err;

  modport master (output start, bit_count, input data, busy, done, sat_err);
  modport slave  (input start, bit_count, output data, busy, done, sat_err);
`else
  modport master (output start, bit_count, input data, busy, done);
  modport slave  (input start, bit_count, output data, busy, done);
`endif
endinterface

// File: rtl/ones_pattern_gen.sv
// Thermometer-code generator: produces min(bit_count, data_width) ones packed in the LSBs.
// Optional sat_err flag is enabled by defining ONES_PATTERN_GEN_SAT_ERR_EN.
module ones_pattern_gen #(
  parameter int data_width  = 4,
  parameter int count_width = 3
) (
  input  logic               clk,
  input  logic               reset,
  ones_pattern_gen_if.slave  bus
);

  // Index and count must both be able to hold the value data_width.
  localparam int CW = $clog2(data_width + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                state_q;
  logic [data_width-1:0] shreg_q;
  logic [CW-1:0]         idx_q;
  logic [CW-1:0]         count_q;
  logic [data_width-1:0] data_q;
  logic                  busy_q;
  logic                  done_q;

  logic [CW-1:0]         count_d;
  logic                  sat_d;
  logic [data_width-1:0] shreg_d;

  // Saturate the requested count to the word width.
  always_comb begin
    count_d = CW'(data_width);
    sat_d   = 1'b0;
    if (int'(bus.bit_count) > data_width) begin
      count_d = CW'(data_width);
      sat_d   = 1'b1;
    end else begin
      count_d = CW'(bus.bit_count);
      sat_d   = 1'b0;
    end
  end

  // Next shift-register value: shift right, inserting a one while index < count.
  always_comb begin
    shreg_d                 = shreg_q >> 1;
    shreg_d[data_width-1]   = (idx_q < count_q) ? 1'b1 : 1'b0;
  end

`ifdef ONES_PATTERN_GEN_SAT_ERR_EN
  logic sat_pend_q;
  logic sat_err_q;
`endif

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef ONES_PATTERN_GEN_SAT_ERR_EN
      sat_pend_q <= 1'b0;
      sat_err_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            count_q <= count_d;
            shreg_q <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
`ifdef ONES_PATTERN_GEN_SAT_ERR_EN
            sat_pend_q <= sat_d;
`endif
          end
        end
        SHIFT: begin
          shreg_q <= shreg_d;
          idx_q   <= idx_q + CW'(1);
          if (idx_q == CW'(data_width - 1)) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          data_q  <= shreg_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
`ifdef ONES_PATTERN_GEN_SAT_ERR_EN
          sat_err_q <= sat_pend_q;
`endif
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.data = data_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef ONES_PATTERN_GEN_SAT_ERR_EN
  assign bus.sat_err = sat_err_q;
`endif

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Scoreboard bench for ones_pattern_gen (data_width=4, count_width=3).
module tb_ones_pattern_gen;

  typedef struct packed {
    logic [3:0] data;
    logic       sat;
  } exp_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  exp_t sb[$];

  ones_pattern_gen_if #(.data_width(4), .count_width(3)) bus ();

  ones_pattern_gen #(.data_width(4), .count_width(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] model(input int c);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (i < c) r[i] = 1'b1;
    end
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.bit_count = 3'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.data !== 4'b0000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: data=%b busy=%b done=%b, required 0000/0/0", bus.data, bus.busy, bus.done);
    end
`ifdef ONES_PATTERN_GEN_SAT_ERR_EN
    checks++;
    if (bus.sat_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_sat_err: got %b, required 0", bus.sat_err);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic run_one(input int c);
    exp_t e;
    int   n;
    bit   seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bit_count = 3'(c);
    e.data = model(c);
    e.sat  = (c > 4);
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_on_accept(c=%0d): got %b, required 1", c, bus.busy);
    end
    seen = 1'b0;
    n = 0;
    for (int j = 0; j < 12 && !seen; j++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        n = j;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout(c=%0d): no done within 12 cycles, required done", c);
    end else begin
      checks++;
      if (n != 5) begin
        errors++;
        $display("FAIL latency(c=%0d): done after edge %0d, required edge 5", c, n);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_at_done(c=%0d): got %b, required 0", c, bus.busy);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.data !== e.data) begin
          errors++;
          $display("FAIL data(c=%0d): got %b, required %b", c, bus.data, e.data);
        end
`ifdef ONES_PATTERN_GEN_SAT_ERR_EN
        checks++;
        if (bus.sat_err !== e.sat) begin
          errors++;
          $display("FAIL sat_err(c=%0d): got %b, required %b", c, bus.sat_err, e.sat);
        end
`endif
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse_width(c=%0d): got %b one cycle later, required 0", c, bus.done);
      end
    end
  endtask

  task automatic test_counts();
    int vals[8] = '{0, 3, 4, 6, 2, 1, 5, 7};
    foreach (vals[i]) run_one(vals[i]);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bit_count = 3'd1;
    for (int k = 0; k < 3; k++) begin
      e.data = model(1);
      e.sat  = 1'b0;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    // Flip bit_count while busy: those edges must not start a new word.
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      if (j == 5 || j == 11 || j == 17) begin
        checks++;
        if (bus.done !== 1'b1) begin
          errors++;
          $display("FAIL b2b_done_edge%0d: got %b, required 1", j, bus.done);
        end else if (sb.size() != 0) begin
          e = sb.pop_front();
          checks++;
          if (bus.data !== e.data) begin
            errors++;
            $display("FAIL b2b_data_edge%0d: got %b, required %b", j, bus.data, e.data);
          end
        end
        bus.bit_count = 3'd1;
      end else begin
        checks++;
        if (bus.done !== 1'b0) begin
          errors++;
          $display("FAIL b2b_spurious_done_edge%0d: got %b, required 0", j, bus.done);
        end
        if (j == 3 || j == 9 || j == 15) bus.bit_count = 3'd4;
        else bus.bit_count = 3'd1;
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_idle_after: busy=%b pending=%0d, required 0/0", bus.busy, sb.size());
    end
  endtask

  task automatic test_reset_abort();
    bit got_done;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bit_count = 3'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.data !== 4'b0000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort_immediate: data=%b busy=%b done=%b, required 0000/0/0", bus.data, bus.busy, bus.done);
    end
    @(negedge clk);
    reset = 1'b0;
    got_done = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (bus.done === 1'b1) got_done = 1'b1;
    end
    checks++;
    if (got_done) begin
      errors++;
      $display("FAIL reset_abort_no_done: got done=1, required no done pulse");
    end
    run_one(3);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_counts();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ones_pattern_gen.md
ONES_PATTERN_GEN -- requirements
Module: ones_pattern_gen

Interface
REQ-001 The block SHALL have parameter data_width, default 4, giving the width of the generated data word.
REQ-002 The block SHALL have parameter count_width, default 3, giving the width of the requested ones count.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start, input, 1 bit: request to generate a word; sampled on the rising edge of clk.
REQ-006 Port bit_count, input, count_width bits: number of ones requested; sampled with start.
REQ-007 Port data, output, data_width bits, registered: the generated word.
REQ-008 Port busy, output, 1 bit, registered: high while a generation is in progress.
REQ-009 Port done, output, 1 bit, registered: one-cycle pulse marking data valid.

Function
REQ-010 The block SHALL implement three states: IDLE, SHIFT and FINISH.
REQ-011 In IDLE, start=1 at an edge SHALL load the working count (bit_count saturated to data_width), clear the shift register and the shift index, set busy=1 and move to SHIFT.
REQ-012 In IDLE with start=0, the block SHALL hold state, and data SHALL keep its last value.
REQ-013 In SHIFT, each edge SHALL right-shift the shift register, inserting 1 at the MSB while index < working count and 0 otherwise, then increment index.
REQ-014 The index SHALL count 0..data_width-1, and SHIFT SHALL last exactly data_width edges before moving to FINISH.
REQ-015 The resulting word SHALL hold min(bit_count, data_width) ones packed in the LSBs, with zeros above them (thermometer code).
REQ-016 In FINISH, one edge SHALL copy the shift register to data, set done=1, clear busy and return to IDLE.
REQ-017 Latency: if start is accepted at edge k, data and done SHALL update at edge k+data_width+1.
REQ-018 done SHALL be high for exactly one cycle per accepted start.
REQ-019 start SHALL be ignored in SHIFT and FINISH; no request is queued.
REQ-020 start=1 in the cycle where done=1 SHALL be accepted, because the state is IDLE; back-to-back throughput is one word per data_width+2 cycles.
REQ-021 A bit_count greater than data_width SHALL saturate to all ones.
REQ-022 bit_count=0 SHALL yield an all-zero word.
REQ-023 Internal index and count widths SHALL hold data_width without overflow.

Reset
REQ-024 Asserting reset SHALL immediately force the state to IDLE and set data=0, busy=0 and done=0, independent of clk.
REQ-025 Reset during SHIFT or FINISH SHALL abort the operation; no done pulse SHALL follow.
REQ-026 The first start accepted after reset deasserts SHALL behave as in REQ-011.

Configuration
REQ-027 When macro ONES_PATTERN_GEN_SAT_ERR_EN is defined, the block SHALL add output port sat_err (1 bit, registered, reset value 0).
REQ-028 With the macro defined, sat_err SHALL be set at the FINISH edge when the latched bit_count exceeded data_width, cleared at the FINISH edge otherwise, and held between FINISH edges.
REQ-029 Without the macro, the port and its logic SHALL be absent, and saturation SHALL still occur silently.

Verification (data_width=4, count_width=3)
REQ-030 start with bit_count=0 at edge 0 -> busy=1 from edge 0; data=4'b0000 and done=1 at edge 5; busy=0 at edge 5.
REQ-031 bit_count=3 -> data=4'b0111 with a single done pulse; bit_count=4 -> data=4'b1111.
REQ-032 bit_count=6 -> data=4'b1111; with ONES_PATTERN_GEN_SAT_ERR_EN, sat_err=1, and a following bit_count=2 -> data=4'b0011 with sat_err=0.
REQ-033 start held high continuously with bit_count=1 -> done at edges 5, 11, 17, each with data=4'b0001; starts during busy are not counted.
REQ-034 start with bit_count=3, then reset pulsed between edges 2 and 3 -> data=0, busy=0 immediately, and no done for that request.
